// File: rtl/simon_decrypt.sv
// Iterative Simon decryptor: expands the round-key schedule on chip,
// then applies the inverse round once per clock, keys in reverse order.
module simon_decrypt #(
  parameter int n = 16,
  parameter int m = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*n-1:0] ciphertext_in,
  input  logic [n*m-1:0] key,
  output logic [2*n-1:0] plaintext,
  output logic           busy,
  output logic           done
);

  function automatic int rounds_f(input int nn, input int mm);
    int r;
    r = 0;
    if (nn == 16 && mm == 4) r = 32;
    else if (nn == 24 && mm == 3) r = 36;
    else if (nn == 24 && mm == 4) r = 36;
    else if (nn == 32 && mm == 3) r = 42;
    else if (nn == 32 && mm == 4) r = 44;
    else if (nn == 48 && mm == 2) r = 52;
    else if (nn == 48 && mm == 3) r = 54;
    else if (nn == 64 && mm == 2) r = 68;
    else if (nn == 64 && mm == 3) r = 69;
    else if (nn == 64 && mm == 4) r = 72;
    return r;
  endfunction

  localparam logic [61:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [61:0] Z1 =
    62'b10001110111110010011000010110101000111011111001001100001011010;
  localparam logic [61:0] Z2 =
    62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [61:0] Z3 =
    62'b11011011101011000110010111100000010010001010011100110100001111;
  localparam logic [61:0] Z4 =
    62'b11010001111001101011011000100000010111000011001010010011101111;

  // Constant sequence chosen by (n, m); string bit 0 is the MSB.
  function automatic logic [61:0] zseq_f(input int nn, input int mm);
    logic [61:0] z;
    z = Z0;
    if (nn == 24 && mm == 4) z = Z1;
    else if ((nn == 32 && mm == 3) || (nn == 48 && mm == 2) ||
             (nn == 64 && mm == 2)) z = Z2;
    else if ((nn == 32 && mm == 4) || (nn == 48 && mm == 3) ||
             (nn == 64 && mm == 3)) z = Z3;
    else if (nn == 64 && mm == 4) z = Z4;
    return z;
  endfunction

  localparam int T = rounds_f(n, m);
  localparam int AW = $clog2(T);
  localparam logic [61:0] Z = zseq_f(n, m);

  if (T == 0) begin : g_illegal
    $error("simon_decrypt: illegal n/m combination");
  end

  function automatic logic [n-1:0] ror(input logic [n-1:0] v,
                                       input int r);
    return (v >> r) | (v << (n - r));
  endfunction

  function automatic logic [n-1:0] rol(input logic [n-1:0] v,
                                       input int r);
    return (v << r) | (v >> (n - r));
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_DECRYPT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [n-1:0]   x_q, x_d;
  logic [n-1:0]   y_q, y_d;
  logic [2*n-1:0] pt_q, pt_d;
  logic [n-1:0]   ks_q [T];

  logic           accept;
  logic [AW-1:0]  ic, i1, i3, im;
  logic [7:0]     ei;
  logic [5:0]     zi, zr;
  logic           zbit;
  logic [n-1:0]   tmp, newk, fy, ynew;

  assign accept = start &&
                  (state_q == S_IDLE || state_q == S_DONE);

  // Key-schedule step for the word at index cnt_q, and inverse round.
  always_comb begin
    ic   = cnt_q[AW-1:0];
    i1   = ic - AW'(1);
    i3   = (m == 4) ? ic - AW'(3) : i1;
    im   = ic - AW'(m);
    ei   = cnt_q - 8'(m);
    zi   = (ei >= 8'd62) ? 6'(ei - 8'd62) : ei[5:0];
    zr   = 6'd61 - zi;
    zbit = Z[zr];
    tmp  = ror(ks_q[i1], 3);
    if (m == 4) tmp = tmp ^ ks_q[i3];
    tmp  = tmp ^ ror(tmp, 1);
    newk = ~ks_q[im] ^ tmp ^ {{(n-1){1'b0}}, zbit} ^
           {{(n-2){1'b0}}, 2'b11};
    fy   = (rol(y_q, 1) & rol(y_q, 8)) ^ rol(y_q, 2);
    ynew = x_q ^ fy ^ ks_q[ic];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    pt_d    = pt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d     = ciphertext_in[2*n-1:n];
          y_d     = ciphertext_in[n-1:0];
          cnt_d   = 8'(m);
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (cnt_q == 8'(T - 1)) begin
          state_d = S_DECRYPT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECRYPT: begin
        x_d = y_q;
        y_d = ynew;
        if (cnt_q == 8'd0) begin
          pt_d    = {y_q, ynew};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pt_q    <= pt_d;
    end
  end

  // Round-key array: key words on start, one derived word per expand cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        for (int i = 0; i < m; i++) begin
          ks_q[AW'(i)] <= key[i*n +: n];
        end
      end else if (state_q == S_EXPAND) begin
        ks_q[ic] <= newk;
      end
    end
  end

  assign plaintext = pt_q;
  assign busy      = (state_q == S_EXPAND) || (state_q == S_DECRYPT);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_simon_decrypt.sv
// Bench for simon_decrypt: known vectors for three geometries plus
// random Simon32/64 traffic checked against a software encryptor.
module tb_simon_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, done;
  logic [31:0] ct, pt;
  logic [63:0] key;

  logic        s24, b24, d24;
  logic [47:0] ct24, pt24;
  logic [71:0] k24;

  logic         s32, b32, d32;
  logic [63:0]  ct32, pt32;
  logic [127:0] k32;

  simon_decrypt #(.n(16), .m(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ciphertext_in(ct), .key(key),
    .plaintext(pt), .busy(busy), .done(done)
  );

  simon_decrypt #(.n(24), .m(3)) dut24 (
    .clk(clk), .rst(rst), .start(s24),
    .ciphertext_in(ct24), .key(k24),
    .plaintext(pt24), .busy(b24), .done(d24)
  );

  simon_decrypt #(.n(32), .m(4)) dut32 (
    .clk(clk), .rst(rst), .start(s32),
    .ciphertext_in(ct32), .key(k32),
    .plaintext(pt32), .busy(b32), .done(d32)
  );

  localparam logic [63:0] K1 = 64'h1918_1110_0908_0100;
  localparam logic [31:0] C1 = 32'hc69b_e9bb;
  localparam logic [31:0] P1 = 32'h6565_6877;

  int total = 0;
  int bad = 0;
  int viol = 0;
  logic [31:0] hold;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rl(input logic [15:0] v, input int r);
    return (v << r) | (v >> (16 - r));
  endfunction

  function automatic logic [15:0] rr(input logic [15:0] v, input int r);
    return (v >> r) | (v << (16 - r));
  endfunction

  // Plain Simon32/64 encryption, forward direction.
  function automatic logic [31:0] enc16(input logic [63:0] k,
                                        input logic [31:0] p);
    logic [15:0] w [32];
    logic [15:0] a, b, t;
    logic [61:0] z;
    z = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) w[i] = k[16*i +: 16];
    for (int i = 4; i < 32; i++) begin
      t = rr(w[i-1], 3) ^ w[i-3];
      t = t ^ rr(t, 1);
      w[i] = ~w[i-4] ^ t ^ 16'(z[61 - ((i - 4) % 62)]) ^ 16'd3;
    end
    a = p[31:16];
    b = p[15:0];
    for (int i = 0; i < 32; i++) begin
      t = a;
      a = b ^ ((rl(a, 1) & rl(a, 8)) ^ rl(a, 2)) ^ w[i];
      b = t;
    end
    return {a, b};
  endfunction

  // One 16-bit decryption; optionally pulses start again mid-run.
  task automatic run16(input logic [63:0] k, input logic [31:0] c,
                       input int pulse_at, input logic [31:0] pc,
                       output int lat);
    @(negedge clk);
    key   = k;
    ct    = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    if (busy !== 1'b1 || done !== 1'b0) viol++;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == pulse_at) begin
        start = 1'b1;
        ct    = pc;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (busy && done) viol++;
      if (!done && pt !== hold) viol++;
    end
    hold = pt;
  endtask

  int lat;
  logic [31:0] rp, rc;
  logic [63:0] rk;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ct    = '0;
    key   = '0;
    s24   = 1'b0;
    ct24  = '0;
    k24   = '0;
    s32   = 1'b0;
    ct32  = '0;
    k32   = '0;
    hold  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pt", 64'(pt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Vector 1: start from IDLE.
    @(negedge clk);
    key   = K1;
    ct    = C1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("v1_busy_nxt", 64'(busy), 64'd1);
    check("v1_pt_held", 64'(pt), 64'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy && done) viol++;
    end
    hold = pt;
    check("v1_lat", 64'(lat), 64'd60);
    check("v1_pt", 64'(pt), 64'(P1));
    check("v1_busy_end", 64'(busy), 64'd0);

    // Restart from DONE, stray start at cycle 20 ignored.
    run16(K1, C1, 19, 32'hdead_beef, lat);
    check("ign20_lat", 64'(lat), 64'd60);
    check("ign20_pt", 64'(pt), 64'(P1));

    // Start held on the edge where done rises is ignored.
    run16(K1, C1, 59, 32'h1234_5678, lat);
    check("edge_lat", 64'(lat), 64'd60);
    check("edge_pt", 64'(pt), 64'(P1));
    @(posedge clk);
    #1;
    check("edge_done_hold", 64'(done), 64'd1);
    check("edge_busy", 64'(busy), 64'd0);

    // Reset in the middle of a run.
    @(negedge clk);
    key   = 64'h0123_4567_89ab_cdef;
    ct    = 32'h0f0f_f0f0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_pt", 64'(pt), 64'd0);
    rst  = 1'b0;
    hold = '0;
    run16(K1, C1, -1, 32'h0, lat);
    check("post_rst_lat", 64'(lat), 64'd60);
    check("post_rst_pt", 64'(pt), 64'(P1));

    // Simon48/72 vector.
    @(negedge clk);
    k24  = 72'h121110_0a0908_020100;
    ct24 = 48'hdae5ac_292cac;
    s24  = 1'b1;
    @(posedge clk);
    #1;
    s24 = 1'b0;
    check("v24_busy", 64'(b24), 64'd1);
    lat = 0;
    while (d24 !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("v24_lat", 64'(lat), 64'((36 - 3) + 36));
    check("v24_pt", 64'(pt24), 64'h6120676e696c);

    // Simon64/128 vector.
    @(negedge clk);
    k32  = 128'h1b1a1918_13121110_0b0a0908_03020100;
    ct32 = 64'h44c8fc20_b9dfa07a;
    s32  = 1'b1;
    @(posedge clk);
    #1;
    s32 = 1'b0;
    check("v32_busy", 64'(b32), 64'd1);
    lat = 0;
    while (d32 !== 1'b1 && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("v32_lat", 64'(lat), 64'((44 - 4) + 44));
    check("v32_pt", 64'(pt32), 64'h656b696c_20646e75);

    // Random traffic with random stray start pulses.
    for (int i = 0; i < 400; i++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      rc = enc16(rk, rp);
      run16(rk, rc, int'($urandom_range(0, 65)), $urandom, lat);
      check("rnd_lat", 64'(lat), 64'd60);
      check("rnd_pt", 64'(pt), 64'(rp));
    end

    check("busy_done_stable", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
